adc_seq: RTL
============

// Module: adc_seq
// PURPOSE
//  Channel sequencer for the 6-bit SAR ADC core. Scans enabled channels round-robin and drives the analog
//  mux select. Waits a settling time, then pulses the ADC start and waits for done. Captures each result,
//  tags it with its channel and presents it on a 1-entry valid/ready output. Sits between the SAR core
//  and the readout logic, in the SAR clock domain.
// PARAMETERS
//  N_CH       4    number of analog input channels (2..16)
//  CH_W       2    channel index width, = clog2(N_CH)
//  RES        6    ADC result width (matches core cap[] width)
//  SETTLE_CYC 3    mux settling cycles after channel switch (>=1)
//  TO_CYC     16   max cycles from adc_start to adc_done before timeout
// PORTS
//  clk       in   1      system clock
//  rst       in   1      asynchronous reset, active-high
//  en        in   1      run enable; continuous scanning while high
//  ch_mask   in   N_CH   channel enable mask, bit i = channel i
//  mux_sel   out  CH_W   analog mux select to front end
//  adc_start out  1      1-cycle conversion start pulse to SAR core
//  adc_done  in   1      1-cycle pulse from core, adc_data valid same cycle
//  adc_data  in   RES    conversion result
//  res_data  out  RES    result to readout
//  res_ch    out  CH_W   channel tag of res_data
//  res_valid out  1      result valid
//  res_ready in   1      readout accepts when res_valid & res_ready
//  ovr       out  1      sticky overrun: unread result overwritten
//  tmo       out  1      sticky timeout: adc_done missing
//  err_clr   in   1      synchronous clear of ovr and tmo
// BEHAVIOUR
//  Reset: state IDLE, mux_sel=0, adc_start=0, res_data=0, res_ch=0, res_valid=0, ovr=0, tmo=0; last_ch=N_CH-1.
//  FSM states: IDLE, SEL, SETTLE, START, CONV, STORE.
//  - IDLE: if en & |ch_mask -> SEL, else stay.
//  - SEL: pick next set bit of ch_mask strictly after last_ch, wrapping. Latch it into mux_sel and last_ch,
//    then -> SETTLE. ch_mask is sampled only here; mask changes apply at the next SEL.
//    If the mask is now 0 -> IDLE.
//  - SETTLE: count SETTLE_CYC cycles, then -> START.
//  - START: adc_start=1 for exactly one cycle -> CONV.
//  - CONV: on adc_done latch adc_data -> STORE. If no done within TO_CYC cycles of START: set tmo,
//    discard the sample, -> SEL, with no res_valid for that channel.
//  - STORE: load res_data/res_ch and set res_valid. If res_valid was already set and not handshaken
//    this cycle: overwrite and set ovr. Next state is SEL if en, else IDLE.
//  Handshake: res_valid clears the cycle after valid&ready unless STORE reloads in the same cycle. If they
//  coincide, the new result wins, res_valid stays 1, and ovr is not set.
//  en low mid-scan: current conversion completes and is stored, then -> IDLE. No adc_start after en falls.
//  Single enabled channel: the same channel repeats, SETTLE included every time.
//  Latency: SEL to res_valid = 1+SETTLE_CYC+1+Tconv+1 cycles.
//  err_clr and a set event in the same cycle: set wins.
//  adc_done outside CONV is ignored.
// CONFIGURATION
//  ADC_SEQ_AVG_EN defined: per channel, 4 back-to-back conversions (SETTLE only before the first).
//  Results accumulate in a RES+2 bit register; res_data = sum>>2 (truncated). Timeout on any of the
//  4 aborts the group. Latency adds 3*(2+Tconv) cycles.
//  Undefined: single conversion per channel, no accumulator logic.
// STRUCTURE
//  adc_seq_pkg: state enum (IDLE..STORE), AVG_N=4 constant, clog2 function.
//  Sub-module rr_pick: combinational round-robin next-index finder (mask, last -> next, found).
//  All other logic is inline.
// TESTING
//  1. ch_mask=4'b1011, en=1, core model done 8 cyc after start -> res_ch seq 0,1,3,0; mux_sel matches.
//     Each adc_start comes 3 cyc after SEL.
//  2. res_ready=0, two STOREs -> res_data = 2nd sample, ovr=1. err_clr pulse -> ovr=0.
//  3. Core never asserts done -> tmo=1 at start+16; no res_valid; next channel selected.
//  4. en dropped during CONV -> result stored, FSM IDLE, no further adc_start.
//     ch_mask=0 with en=1 -> stays IDLE.
//  5. rst asserted mid-CONV -> all outputs at reset values immediately.
//     After release, first channel selected is 0.
//  6. ADC_SEQ_AVG_EN, samples 10,11,12,13 on ch2 -> res_data=11, res_ch=2; 4 adc_start, 1 settle.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the SAR ADC channel sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SETTLE,
    START,
    CONV,
    STORE
  } seqState_e;

  localparam int unsigned AVG_N = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_seq_rr_pick.sv
// Round-robin next-channel finder: first set mask bit strictly after 'last', wrapping.
module rr_pick
  import adc_seq_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] last,
  output logic [CH_W-1:0] next,
  output logic            found
);

  logic [CH_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    next  = last;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = N_CH; i >= 1; i--) begin
      idx = CH_W'((32'(last) + i) % N_CH);
      if (mask[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_seq.sv
// Channel sequencer for the 6-bit SAR ADC core: round-robin scan, settle, convert, 1-entry result.
// Optional build macro ADC_SEQ_AVG_EN: average AVG_N back-to-back conversions per channel.
module adc_seq
  import adc_seq_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CH_W       = clog2(N_CH),
  parameter int unsigned RES        = 6,
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned TO_CYC     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] ch_mask,
  output logic [CH_W-1:0] mux_sel,
  output logic            adc_start,
  input  logic            adc_done,
  input  logic [RES-1:0]  adc_data,
  output logic [RES-1:0]  res_data,
  output logic [CH_W-1:0] res_ch,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            ovr,
  output logic            tmo,
  input  logic            err_clr
);

  localparam int unsigned     CNT_MAX     = (TO_CYC > SETTLE_CYC) ? TO_CYC : SETTLE_CYC;
  localparam int unsigned     CNT_W       = clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TO_CYC - 1);
  localparam logic [CH_W-1:0]  LAST_INIT   = CH_W'(N_CH - 1);

  seqState_e       state;
  logic [CH_W-1:0] lastCh;
  logic [CH_W-1:0] pickCh;
  logic            pickFound;
  logic [CNT_W-1:0] cnt;
  logic [RES-1:0]  sample;
  logic            midGroup;

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) uPick (
    .mask  (ch_mask),
    .last  (lastCh),
    .next  (pickCh),
    .found (pickFound)
  );

`ifdef ADC_SEQ_AVG_EN
  localparam int unsigned GRP_W = clog2(AVG_N);
  logic [GRP_W-1:0] grp;
  logic [RES+1:0]   acc;
  logic [RES+1:0]   accNext;

  always_comb begin
    accNext  = acc + (RES+2)'(adc_data);
    midGroup = (grp != '0);
  end
`else
  always_comb midGroup = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mux_sel   <= '0;
      lastCh    <= LAST_INIT;
      adc_start <= 1'b0;
      cnt       <= '0;
      sample    <= '0;
      res_data  <= '0;
      res_ch    <= '0;
      res_valid <= 1'b0;
      ovr       <= 1'b0;
      tmo       <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
      grp       <= '0;
      acc       <= '0;
`endif
    end else begin
      adc_start <= 1'b0;
      // Clears are written first so a same-cycle set further down takes precedence.
      if (err_clr) begin
        ovr <= 1'b0;
        tmo <= 1'b0;
      end
      if (res_valid && res_ready) res_valid <= 1'b0;

      case (state)
        IDLE: if (en && (|ch_mask)) state <= SEL;

        SEL: begin
          if (en && pickFound) begin
            mux_sel <= pickCh;
            lastCh  <= pickCh;
            cnt     <= '0;
`ifdef ADC_SEQ_AVG_EN
            grp     <= '0;
            acc     <= '0;
`endif
            state   <= SETTLE;
          end else begin
            state <= IDLE;
          end
        end

        // Inside an averaging group this state is entered with cnt preset, giving one gap cycle.
        SETTLE: begin
          if (!en && !midGroup) begin
            state <= IDLE;
          end else if (cnt == SETTLE_LAST) begin
            adc_start <= 1'b1;
            state     <= START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        START: begin
          cnt   <= CNT_W'(1);
          state <= CONV;
        end

        CONV: begin
          if (adc_done) begin
`ifdef ADC_SEQ_AVG_EN
            if (grp == GRP_W'(AVG_N - 1)) begin
              sample <= RES'(accNext >> 2);
              state  <= STORE;
            end else begin
              acc   <= accNext;
              grp   <= grp + 1'b1;
              cnt   <= SETTLE_LAST;
              state <= SETTLE;
            end
`else
            sample <= adc_data;
            state  <= STORE;
`endif
          end else if (cnt == TO_LAST) begin
            tmo   <= 1'b1;
            state <= en ? SEL : IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STORE: begin
          res_data  <= sample;
          res_ch    <= mux_sel;
          if (res_valid && !res_ready) ovr <= 1'b1;
          res_valid <= 1'b1;
          state     <= en ? SEL : IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
